counter: RTL and testbench
==========================

// Module: counter
// PURPOSE
//   Loadable, enable-gated binary up-counter. It is the VeriRisc CPU program counter.
//   - Holds the current instruction address.
//   - Increments to step through program memory.
//   - Parallel-loads a jump/branch target.
//   Single clock domain; purely registered output, no combinational path from inputs to cnt_out.
// PARAMETERS
//   WIDTH   5   Bit width of cnt_in and cnt_out (counter modulus 2**WIDTH); legal range >= 1
// PORTS
//   clk      input   1       Rising-edge clock; all state changes occur on posedge clk
//   rst      input   1       Reset; asynchronous, active-low (rst=0 resets)
//   load     input   1       Synchronous parallel-load request (active-high)
//   enab     input   1       Synchronous count enable (active-high)
//   cnt_in   input   WIDTH   Parallel-load value
//   cnt_out  output  WIDTH   Current count (registered)
// BEHAVIOUR
//   - One clock; reset is asynchronous and active-low.
//     - Clock port name: clk.
//     - Reset port name: rst.
//     - rst=0 forces cnt_out to 0 immediately, independent of clk.
//     - cnt_out is held at 0 for as long as rst=0.
//   - Reset value: cnt_out = {WIDTH{1'b0}}.
//   - Reset release: the first update occurs on the first posedge clk with rst=1.
//   - Priority at each posedge clk (rst=1), highest first:
//     1. load=1            : cnt_out <= cnt_in. enab is ignored.
//     2. load=0, enab=1    : cnt_out <= cnt_out + 1, modulo 2**WIDTH.
//     3. load=0, enab=0    : cnt_out holds its value.
//   - Latency: one cycle. A value presented before posedge N is visible on cnt_out after posedge N.
//   - Wrap-around: all-ones + 1 -> 0. No carry/terminal-count output; overflow is silent.
//   - Load with load=1 and enab=1: load wins, with no increment in the same cycle.
//   - Reloading the current value is allowed; the count is unchanged.
//   - Reset mid-operation: asserting rst overrides any pending load/increment and clears cnt_out at once.
//     Counting resumes from 0 after release.
//   - X/Z on load/enab with rst=1 is illegal; behaviour is unspecified.
//   - Arithmetic is unsigned; only the low WIDTH bits are kept.
// TESTING
//   Drive inputs on negedge clk and check cnt_out at the next negedge. WIDTH=5 throughout.
//   1. Load: rst=1, load=1, enab=1, cnt_in=5'h15 -> cnt_out=5'h15.
//      Then cnt_in=5'h0A -> 5'h0A.
//      Then cnt_in=5'h1F -> 5'h1F.
//   2. Async reset: from cnt_out=5'h1F, drop rst=0 mid-cycle with load=1, cnt_in=5'h1F.
//      -> cnt_out=5'h00 before the next posedge, and it stays 0 while rst=0.
//   3. Reload after reset: rst=1, load=1, cnt_in=5'h1F -> cnt_out=5'h1F.
//   4. Wrap: from 5'h1F, set load=0, enab=1 -> cnt_out=5'h00.
//      The following cycle -> 5'h01.
//   5. Hold: load=0, enab=0 with cnt_out=5'h01 for 3 cycles -> remains 5'h01.
//      Then enab=1 for 3 cycles -> 5'h02, 5'h03, 5'h04.
//   6. Priority: cnt_out=5'h04, load=1, enab=1, cnt_in=5'h10 -> 5'h10 (not 5'h11).

Source files
------------

// File: rtl/counter.sv
// Program counter for the VeriRisc CPU.
// A loadable, enable-gated binary up-counter with an asynchronous active-low clear.
module counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enab,
  input  logic [WIDTH-1:0] cnt_in,
  output logic [WIDTH-1:0] cnt_out
);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_inc;

  // Truncation to WIDTH bits makes all-ones wrap silently to zero.
  assign w_cnt_inc = r_cnt + WIDTH'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= cnt_in;
    end else if (enab) begin
      r_cnt <= w_cnt_inc;
    end
  end

  assign cnt_out = r_cnt;

endmodule

// File: tb/tb_counter.sv
// Directed test of the program counter: literal checkpoints plus a per-cycle
// comparison against an arithmetic model of the load/increment/hold rules.
module tb_counter;
  localparam int W   = 5;
  localparam int MOD = 1 << W;

  logic         clk;
  logic         rst;
  logic         load;
  logic         enab;
  logic [W-1:0] cnt_in;
  logic [W-1:0] cnt_out;

  int total;
  int bad;
  int model_cnt;
  bit cmp_en;

  counter #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .enab    (enab),
    .cnt_in  (cnt_in),
    .cnt_out (cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the count is an integer in [0, MOD); reset clears it immediately.
  always @(posedge clk or negedge rst) begin
    if (!rst)
      model_cnt <= 0;
    else if (load)
      model_cnt <= int'(cnt_in);
    else if (enab)
      model_cnt <= (model_cnt + 1) % MOD;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end else begin
      $display("ok   %s: cnt_out=0x%02h", name, act);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) check("model", int'(cnt_out), model_cnt);
  end

  task automatic drive(input logic l, input logic e, input logic [W-1:0] d);
    load   = l;
    enab   = e;
    cnt_in = d;
  endtask

  task automatic step_check(input string name, input int exp);
    @(negedge clk);
    check(name, int'(cnt_out), exp);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    cmp_en = 1'b0;
    rst    = 1'b1;
    drive(1'b0, 1'b0, '0);
    #1 rst = 1'b0;
    #2 check("reset_value", int'(cnt_out), 0);
    @(negedge clk);
    drive(1'b1, 1'b1, 5'h07);
    @(negedge clk);
    check("reset_holds_with_load", int'(cnt_out), 0);
    rst    = 1'b1;
    cmp_en = 1'b1;

    // Load sequence
    drive(1'b1, 1'b1, 5'h15);
    step_check("load_15", 32'h15);
    drive(1'b1, 1'b1, 5'h0A);
    step_check("load_0A", 32'h0A);
    drive(1'b1, 1'b1, 5'h1F);
    step_check("load_1F", 32'h1F);

    // Asynchronous clear in the middle of a cycle with a load pending
    drive(1'b1, 1'b0, 5'h1F);
    #2 rst = 1'b0;
    #1 check("async_clear", int'(cnt_out), 0);
    step_check("clear_held_1", 0);
    step_check("clear_held_2", 0);

    // Reload after release
    rst = 1'b1;
    drive(1'b1, 1'b0, 5'h1F);
    step_check("reload_1F", 32'h1F);

    // Wrap-around
    drive(1'b0, 1'b1, 5'h00);
    step_check("wrap_00", 0);
    step_check("wrap_01", 1);

    // Hold, then count
    drive(1'b0, 1'b0, 5'h1B);
    step_check("hold_1", 1);
    step_check("hold_2", 1);
    step_check("hold_3", 1);
    drive(1'b0, 1'b1, 5'h1B);
    step_check("count_02", 2);
    step_check("count_03", 3);
    step_check("count_04", 4);

    // Load has priority over enable
    drive(1'b1, 1'b1, 5'h10);
    step_check("priority_10", 32'h10);

    // Reloading the current value leaves it unchanged
    drive(1'b1, 1'b0, 5'h10);
    step_check("reload_same", 32'h10);

    // Mixed traffic checked by the model on every cycle
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), W'($urandom));
      if (i == 40) begin
        #2 rst = 1'b0;
        #1 check("async_clear_random", int'(cnt_out), 0);
        #1 rst = 1'b1;
      end
      @(negedge clk);
    end

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
